// File: rtl/fetch_pkg.sv
// fetch_pkg
// Types and default sizing shared by the fetch scheduler, the per-warp ITS
// units and the instruction fetcher.
// - sched_state_e : kernel-launch sequence IDLE -> INIT -> RUN -> DRAIN.
// - fetch_req_t   : one fetch request {pc, act_mask, warp_id, subwarp_id}.
// The field widths of fetch_req_t follow the constants below. A module
// parameterised differently from these constants would not match the
// request type.
package fetch_pkg;

  localparam int NUM_WARPS        = 8;
  localparam int WARP_WIDTH       = 32;
  localparam int PC_WIDTH         = 32;
  localparam int MAX_INFLIGHT     = 4;
  localparam int WARP_ID_WIDTH    = $clog2(NUM_WARPS);
  localparam int SUBWARP_ID_WIDTH = $clog2(WARP_WIDTH);
  localparam int CREDIT_WIDTH     = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]         pc;
    logic [WARP_WIDTH-1:0]       act_mask;
    logic [WARP_ID_WIDTH-1:0]    warp_id;
    logic [SUBWARP_ID_WIDTH-1:0] subwarp_id;
  } fetch_req_t;

endpackage

// File: rtl/fetch_rr_picker.sv
// fetch_rr_picker
// Round-robin picker: a search pointer plus a rotated priority encoder.
// The search starts at the pointer and wraps modulo N. The pointer moves to
// (winner+1)%N only when a grant is actually given, so a warp that misses a
// cycle because the picker was disabled keeps its turn.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (pointer -> 0)
//   req        per-requester request vector
//   en         picker may grant this cycle
//   gnt        one-hot grant (all zero when no grant)
//   idx        index of the granted requester (0 when no grant)
//   valid      a grant is given this cycle
module fetch_rr_picker #(
  parameter  int N   = 8,
  localparam int IdW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] idx,
  output logic           valid
);

  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] cand;

  // Offsets are scanned from farthest to nearest so that the last hit,
  // which is the one closest to the pointer, is the one that sticks.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    if (en) begin
      for (int off = N - 1; off >= 0; off--) begin
        cand = IdW'((int'(ptr_q) + off) % N);
        if (req[cand]) begin
          valid = 1'b1;
          idx   = cand;
        end
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (valid) begin
      ptr_q <= (idx == IdW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// warp_fetch_scheduler
// Fetch-side scheduler for one compute unit. Runs the kernel launch
// (start -> init enabled warps with a common PC -> run -> drain -> done),
// grants one ready warp per cycle round-robin, registers the winner into a
// valid/ready fetch request and bounds in-flight fetches with credits.
//
// Handshake: fetch_req_o is offered while fetch_valid_o is high and is
// transferred on a rising edge where fetch_valid_o & fetch_ready_i. While
// fetch_valid_o & ~fetch_ready_i the request holds stable. A new grant may
// be registered in the same cycle as an accept, giving one request/cycle.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i/start_pc_i/warp_en_i   launch request, entry PC, participating warps
//   stop_i              abort in RUN: stop issuing and drain
//   busy_o, done_o      not idle; one-cycle pulse on DRAIN -> IDLE
//   warp_init_o/warp_init_pc_o     per-warp init pulse and the latched PC
//   warp_ready_i/warp_pc_i/warp_act_mask_i/warp_subwarp_id_i  per-warp offer
//   warp_selected_o     one-hot grant, same cycle as the offer
//   warp_finished_i     per-warp exit retired
//   fetch_valid_o/fetch_ready_i/fetch_req_o   fetch request channel
//   credit_return_i     decoder consumed one fetched instruction
//   state_o, credits_o  debug view of the FSM state and credit count
module warp_fetch_scheduler
  import fetch_pkg::*;
#(
  parameter  int NumWarps       = NUM_WARPS,
  parameter  int WarpWidth      = WARP_WIDTH,
  parameter  int PcWidth        = PC_WIDTH,
  parameter  int MaxInflight    = MAX_INFLIGHT,
  localparam int WarpIdWidth    = $clog2(NumWarps),
  localparam int SubwarpIdWidth = $clog2(WarpWidth),
  localparam int CreditWidth    = $clog2(MaxInflight + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [PcWidth-1:0]                 start_pc_i,
  input  logic [NumWarps-1:0]                warp_en_i,
  input  logic                               stop_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [NumWarps-1:0]                warp_init_o,
  output logic [PcWidth-1:0]                 warp_init_pc_o,
  input  logic [NumWarps-1:0]                warp_ready_i,
  input  logic [NumWarps*PcWidth-1:0]        warp_pc_i,
  input  logic [NumWarps*WarpWidth-1:0]      warp_act_mask_i,
  input  logic [NumWarps*SubwarpIdWidth-1:0] warp_subwarp_id_i,
  output logic [NumWarps-1:0]                warp_selected_o,
  input  logic [NumWarps-1:0]                warp_finished_i,
  output logic                               fetch_valid_o,
  input  logic                               fetch_ready_i,
  output fetch_req_t                         fetch_req_o,
  input  logic                               credit_return_i,
  output sched_state_e                       state_o,
  output logic [CreditWidth-1:0]             credits_o
);

  localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(MaxInflight);

  sched_state_e             state_q, state_d;
  logic [NumWarps-1:0]      en_q;
  logic [PcWidth-1:0]       pc_q;
  logic [CreditWidth-1:0]   credits_q;
  logic                     valid_q;
  fetch_req_t               req_q;

  logic [NumWarps-1:0]      eligible;
  logic                     all_finished;
  logic                     grant_ok;
  logic                     grant;
  logic [NumWarps-1:0]      gnt;
  logic [WarpIdWidth-1:0]   gnt_idx;
  logic                     done;

  assign eligible     = warp_ready_i & en_q & ~warp_finished_i;
  // Disabled warps count as finished; an empty mask never reaches RUN.
  assign all_finished = &(~en_q | warp_finished_i);

  // ---------------- FSM ----------------
  always_comb begin
    state_d  = state_q;
    grant_ok = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE:  if (start_i) state_d = INIT;
      INIT:  state_d = (en_q == '0) ? DRAIN : RUN;
      RUN: begin
        if (stop_i || all_finished) begin
          state_d = DRAIN;
        end else begin
          grant_ok = (credits_q != '0) && (!valid_q || fetch_ready_i);
        end
      end
      DRAIN: begin
        if (!valid_q && credits_q == CreditMax) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      en_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        en_q <= warp_en_i;
        pc_q <= start_pc_i;
      end
    end
  end

  // ---------------- Arbitration ----------------
  fetch_rr_picker #(.N(NumWarps)) u_picker (
    .clk   (clk_i),
    .rst   (rst_i),
    .req   (eligible),
    .en    (grant_ok),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .valid (grant)
  );

  // ---------------- Credits ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits_q <= CreditMax;
    end else if (grant && !credit_return_i) begin
      credits_q <= credits_q - 1'b1;
    end else if (credit_return_i && !grant && credits_q != CreditMax) begin
      credits_q <= credits_q + 1'b1;
    end
  end

  // ---------------- Output register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (grant) begin
      valid_q          <= 1'b1;
      req_q.pc         <= warp_pc_i[gnt_idx*PcWidth +: PcWidth];
      req_q.act_mask   <= warp_act_mask_i[gnt_idx*WarpWidth +: WarpWidth];
      req_q.warp_id    <= gnt_idx;
      req_q.subwarp_id <= warp_subwarp_id_i[gnt_idx*SubwarpIdWidth +: SubwarpIdWidth];
    end else if (fetch_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign done_o          = done;
  assign warp_init_o     = (state_q == INIT) ? en_q : '0;
  assign warp_init_pc_o  = pc_q;
  assign warp_selected_o = gnt;
  assign fetch_valid_o   = valid_q;
  assign fetch_req_o     = req_q;
  assign state_o         = state_q;
  assign credits_o       = credits_q;

  // ---------------- Assertions ----------------
  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(warp_selected_o));
  a_grant_eligible: assert property (@(posedge clk_i) disable iff (rst_i)
    (warp_selected_o & ~eligible) == '0);
  a_idle_no_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    !busy_o |-> !fetch_valid_o);
  a_credit_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(credit_return_i && !grant && credits_q == CreditMax));

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
module tb_warp_fetch_scheduler;
  import fetch_pkg::*;

  localparam int NW  = NUM_WARPS;
  localparam int PW  = PC_WIDTH;
  localparam int WW  = WARP_WIDTH;
  localparam int SW  = SUBWARP_ID_WIDTH;
  localparam int CW  = CREDIT_WIDTH;

  logic                clk;
  logic                rst_i;
  logic                start_i;
  logic [PW-1:0]       start_pc_i;
  logic [NW-1:0]       warp_en_i;
  logic                stop_i;
  logic                busy_o;
  logic                done_o;
  logic [NW-1:0]       warp_init_o;
  logic [PW-1:0]       warp_init_pc_o;
  logic [NW-1:0]       warp_ready_i;
  logic [NW*PW-1:0]    warp_pc_i;
  logic [NW*WW-1:0]    warp_act_mask_i;
  logic [NW*SW-1:0]    warp_subwarp_id_i;
  logic [NW-1:0]       warp_selected_o;
  logic [NW-1:0]       warp_finished_i;
  logic                fetch_valid_o;
  logic                fetch_ready_i;
  fetch_req_t          fetch_req_o;
  logic                credit_return_i;
  sched_state_e        state_o;
  logic [CW-1:0]       credits_o;

  int checks = 0;
  int errors = 0;

  // ---------------- Clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  warp_fetch_scheduler dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .start_pc_i        (start_pc_i),
    .warp_en_i         (warp_en_i),
    .stop_i            (stop_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .warp_init_o       (warp_init_o),
    .warp_init_pc_o    (warp_init_pc_o),
    .warp_ready_i      (warp_ready_i),
    .warp_pc_i         (warp_pc_i),
    .warp_act_mask_i   (warp_act_mask_i),
    .warp_subwarp_id_i (warp_subwarp_id_i),
    .warp_selected_o   (warp_selected_o),
    .warp_finished_i   (warp_finished_i),
    .fetch_valid_o     (fetch_valid_o),
    .fetch_ready_i     (fetch_ready_i),
    .fetch_req_o       (fetch_req_o),
    .credit_return_i   (credit_return_i),
    .state_o           (state_o),
    .credits_o         (credits_o)
  );

  // Warp k offers pc 0x1000+4k, mask 0xF000_0000|k, subwarp id k.
  function automatic logic [PW-1:0] exp_pc(input int k);
    return PW'(32'h1000 + 4 * k);
  endfunction

  // ---------------- Driver tasks ----------------
  task automatic apply_reset();
    rst_i           = 1'b1;
    start_i         = 1'b0;
    start_pc_i      = '0;
    warp_en_i       = '0;
    stop_i          = 1'b0;
    warp_ready_i    = '0;
    warp_finished_i = '0;
    fetch_ready_i   = 1'b0;
    credit_return_i = 1'b0;
    for (int k = 0; k < NW; k++) begin
      warp_pc_i[k*PW +: PW]         = exp_pc(k);
      warp_act_mask_i[k*WW +: WW]   = 32'hF000_0000 | WW'(k);
      warp_subwarp_id_i[k*SW +: SW] = SW'(k);
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Returns on the negedge of the first RUN cycle.
  task automatic launch(input logic [PW-1:0] pc, input logic [NW-1:0] en);
    @(negedge clk);
    start_i    = 1'b1;
    start_pc_i = pc;
    warp_en_i  = en;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset_values();
    apply_reset();
    #1;
    checks++;
    if (state_o !== IDLE || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d busy=%b done=%b, want state=0 busy=0 done=0",
               state_o, busy_o, done_o);
    end
    checks++;
    if (fetch_valid_o !== 1'b0 || warp_selected_o !== '0 || warp_init_o !== '0
        || credits_o !== CW'(4)) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b sel=%b init=%b credits=%0d, want 0 0 0 4",
               fetch_valid_o, warp_selected_o, warp_init_o, credits_o);
    end
  endtask

  task automatic test_launch();
    apply_reset();
    @(negedge clk);
    start_i    = 1'b1;
    start_pc_i = 32'h100;
    warp_en_i  = 8'b0000_0101;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (state_o !== INIT || warp_init_o !== 8'b0000_0101 || warp_init_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL launch_init: state=%0d init=%b pc=%h, want state=1 init=00000101 pc=100",
               state_o, warp_init_o, warp_init_pc_o);
    end
    @(negedge clk);
    checks++;
    if (state_o !== RUN || warp_init_o !== '0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL launch_run: state=%0d init=%b busy=%b, want state=2 init=0 busy=1",
               state_o, warp_init_o, busy_o);
    end
    // Both enabled warps retire: RUN -> DRAIN -> IDLE with done.
    warp_finished_i = 8'b0000_0101;
    @(negedge clk);
    checks++;
    if (state_o !== DRAIN || done_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL launch_finish_drain: state=%0d done=%b busy=%b, want 3 1 1",
               state_o, done_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (state_o !== IDLE || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL launch_finish_idle: state=%0d done=%b busy=%b, want 0 0 0",
               state_o, done_o, busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic [NW-1:0] one;
    apply_reset();
    launch(32'h200, 8'hFF);
    warp_ready_i    = 8'hFF;
    fetch_ready_i   = 1'b1;
    credit_return_i = 1'b1;
    one = 8'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (warp_selected_o !== (one << (i % NW))) begin
        errors++;
        $display("FAIL rr_grant[%0d]: sel=%b, want %b", i, warp_selected_o, one << (i % NW));
      end
      if (i > 0) begin
        checks++;
        if (fetch_valid_o !== 1'b1 || fetch_req_o.warp_id !== 3'((i - 1) % NW)
            || fetch_req_o.pc !== exp_pc((i - 1) % NW)) begin
          errors++;
          $display("FAIL rr_req[%0d]: valid=%b id=%0d pc=%h, want 1 %0d %h", i,
                   fetch_valid_o, fetch_req_o.warp_id, fetch_req_o.pc,
                   (i - 1) % NW, exp_pc((i - 1) % NW));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (credits_o !== CW'(4)) begin
      errors++;
      $display("FAIL rr_credits: credits=%0d, want 4", credits_o);
    end
  endtask

  task automatic test_credit_limit();
    logic [NW-1:0] one;
    apply_reset();
    launch(32'h300, 8'hFF);
    warp_ready_i  = 8'hFF;
    fetch_ready_i = 1'b1;
    one = 8'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (warp_selected_o !== (one << i)) begin
        errors++;
        $display("FAIL credit_grant[%0d]: sel=%b, want %b", i, warp_selected_o, one << i);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (warp_selected_o !== '0 || credits_o !== '0) begin
        errors++;
        $display("FAIL credit_block[%0d]: sel=%b credits=%0d, want 0 0", i,
                 warp_selected_o, credits_o);
      end
      @(negedge clk);
    end
    // Return lands at the edge; the grant it enables comes the cycle after.
    credit_return_i = 1'b1;
    #1;
    checks++;
    if (warp_selected_o !== '0) begin
      errors++;
      $display("FAIL credit_return_cycle: sel=%b, want 0", warp_selected_o);
    end
    @(negedge clk);
    credit_return_i = 1'b0;
    #1;
    checks++;
    if (warp_selected_o !== 8'b0001_0000 || credits_o !== CW'(1)) begin
      errors++;
      $display("FAIL credit_extra_grant: sel=%b credits=%0d, want 00010000 1",
               warp_selected_o, credits_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (warp_selected_o !== '0 || credits_o !== '0) begin
      errors++;
      $display("FAIL credit_after_extra: sel=%b credits=%0d, want 0 0",
               warp_selected_o, credits_o);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    launch(32'h400, 8'hFF);
    warp_ready_i  = 8'b0000_0110;
    fetch_ready_i = 1'b0;
    #1;
    checks++;
    if (warp_selected_o !== 8'b0000_0010) begin
      errors++;
      $display("FAIL bp_first_grant: sel=%b, want 00000010", warp_selected_o);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (warp_selected_o !== '0 || fetch_valid_o !== 1'b1 || fetch_req_o.warp_id !== 3'd1
          || fetch_req_o.pc !== 32'h1004 || fetch_req_o.act_mask !== 32'hF000_0001
          || fetch_req_o.subwarp_id !== 5'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: sel=%b valid=%b id=%0d pc=%h mask=%h sw=%0d, want 0 1 1 1004 f0000001 1",
                 i, warp_selected_o, fetch_valid_o, fetch_req_o.warp_id, fetch_req_o.pc,
                 fetch_req_o.act_mask, fetch_req_o.subwarp_id);
      end
      @(negedge clk);
    end
    fetch_ready_i = 1'b1;
    #1;
    checks++;
    if (warp_selected_o !== 8'b0000_0100) begin
      errors++;
      $display("FAIL bp_resume: sel=%b, want 00000100", warp_selected_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fetch_valid_o !== 1'b1 || fetch_req_o.warp_id !== 3'd2 || credits_o !== CW'(2)) begin
      errors++;
      $display("FAIL bp_next_req: valid=%b id=%0d credits=%0d, want 1 2 2",
               fetch_valid_o, fetch_req_o.warp_id, credits_o);
    end
  endtask

  task automatic test_stop_drain();
    apply_reset();
    launch(32'h500, 8'hFF);
    warp_ready_i  = 8'hFF;
    fetch_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    stop_i = 1'b1;
    #1;
    checks++;
    if (warp_selected_o !== '0 || credits_o !== CW'(2) || state_o !== RUN) begin
      errors++;
      $display("FAIL stop_no_issue: sel=%b credits=%0d state=%0d, want 0 2 2",
               warp_selected_o, credits_o, state_o);
    end
    @(negedge clk);
    stop_i = 1'b0;
    #1;
    checks++;
    if (state_o !== DRAIN || warp_selected_o !== '0 || fetch_valid_o !== 1'b0
        || done_o !== 1'b0) begin
      errors++;
      $display("FAIL stop_drain: state=%0d sel=%b valid=%b done=%b, want 3 0 0 0",
               state_o, warp_selected_o, fetch_valid_o, done_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      credit_return_i = 1'b1;
      #1;
      checks++;
      if (done_o !== 1'b0 || state_o !== DRAIN) begin
        errors++;
        $display("FAIL stop_wait[%0d]: done=%b state=%0d, want 0 3", i, done_o, state_o);
      end
    end
    @(negedge clk);
    credit_return_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b1 || credits_o !== CW'(4)) begin
      errors++;
      $display("FAIL stop_done: done=%b busy=%b credits=%0d, want 1 1 4",
               done_o, busy_o, credits_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || state_o !== IDLE) begin
      errors++;
      $display("FAIL stop_idle: busy=%b done=%b state=%0d, want 0 0 0",
               busy_o, done_o, state_o);
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    launch(32'h600, 8'hFF);
    warp_ready_i  = 8'hFF;
    fetch_ready_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (fetch_valid_o !== 1'b1 || state_o !== RUN) begin
      errors++;
      $display("FAIL midrun_pre: valid=%b state=%0d, want 1 2", fetch_valid_o, state_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || fetch_valid_o !== 1'b0 || credits_o !== CW'(4)
        || warp_selected_o !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b valid=%b credits=%0d sel=%b, want 0 0 4 0",
               busy_o, fetch_valid_o, credits_o, warp_selected_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || fetch_valid_o !== 1'b0 || state_o !== IDLE) begin
      errors++;
      $display("FAIL midrun_after: busy=%b valid=%b state=%0d, want 0 0 0",
               busy_o, fetch_valid_o, state_o);
    end
  endtask

  // ---------------- Sequence and report ----------------
  initial begin
    test_reset_values();
    test_launch();
    test_round_robin();
    test_credit_limit();
    test_backpressure();
    test_stop_drain();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
